// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// driving datapath controls, inter-stage load enables and a data-memory req/ack handshake.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
  input  logic             Mem_Ack,
  output logic             IR_LdEn,
  output logic             AB_LdEn,
  output logic             ALUOut_LdEn,
  output logic             MDR_LdEn,
  output logic             PC_Sel,
  output logic             PC_LdEn,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             Mem_Req,
  output logic             Mem_WrEn,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Instr_Count
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state, nextState;

  logic [5:0] opcode;
  logic       isR, isLi, isAddi, isAndi, isOri, isBeq, isBne, isB, isLw, isSw;
  logic       isImm, isBr, isMem;

  assign opcode = Instr[31:26];
  assign isR    = (opcode == 6'b100000);
  assign isLi   = (opcode == 6'b111000);
  assign isAddi = (opcode == 6'b110000);
  assign isAndi = (opcode == 6'b110010);
  assign isOri  = (opcode == 6'b110011);
  assign isBeq  = (opcode == 6'b000000);
  assign isBne  = (opcode == 6'b000001);
  assign isB    = (opcode == 6'b111111);
  assign isLw   = (opcode == 6'b001111);
  assign isSw   = (opcode == 6'b011111);
  assign isImm  = isLi | isAddi | isAndi | isOri;
  assign isBr   = isBeq | isBne | isB;
  assign isMem  = isLw | isSw;

  // Mealy decode; everything is gated off while Reset is low so no stale request leaks out.
  always_comb begin
    IR_LdEn       = 1'b0;
    AB_LdEn       = 1'b0;
    ALUOut_LdEn   = 1'b0;
    MDR_LdEn      = 1'b0;
    PC_Sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'd0;
    Mem_Req       = 1'b0;
    Mem_WrEn      = 1'b0;
    nextState     = FETCH;
    if (Reset) begin
      case (state)
        FETCH: begin
          IR_LdEn   = 1'b1;
          nextState = DECODE;
        end
        DECODE: begin
          AB_LdEn   = 1'b1;
          RF_B_sel  = isImm | isBr | isMem;
          nextState = EXEC;
        end
        EXEC: begin
          ALUOut_LdEn = 1'b1;
          ALU_Bin_sel = isImm | isMem;
          if (isR)                ALU_func = Instr[3:0];
          else if (isAndi)        ALU_func = 4'd2;
          else if (isOri)         ALU_func = 4'd3;
          else if (isBeq | isBne) ALU_func = 4'd1;
          if (isR | isImm) nextState = WB;
          else if (isMem)  nextState = MEM;
          else begin
            // branches and NOPs retire here
            PC_LdEn   = 1'b1;
            PC_Sel    = isB | (isBeq & Zero) | (isBne & ~Zero);
            nextState = FETCH;
          end
        end
        MEM: begin
          Mem_Req  = 1'b1;
          Mem_WrEn = isSw;
          if (!Mem_Ack)   nextState = MEM;
          else if (isLw) begin
            MDR_LdEn  = 1'b1;
            nextState = WB;
          end else begin
            PC_LdEn   = 1'b1;
            nextState = FETCH;
          end
        end
        WB: begin
          RF_WrEn       = 1'b1;
          PC_LdEn       = 1'b1;
          RF_WrData_sel = ~isLw;
          nextState     = FETCH;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= FETCH;
      Instr_Count <= '0;
    end else begin
      state <= nextState;
      if (PC_LdEn) Instr_Count <= Instr_Count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench for multicycle_control: per-instruction state sequences are
// derived from the instruction class and memory wait, expected outputs queued per cycle.
module tb_multicycle_control;
  localparam int CW = 4;

  logic          Clk = 1'b0, Reset = 1'b0, Zero = 1'b0, Mem_Ack = 1'b0;
  logic [31:0]   Instr = '0;
  logic          IR_LdEn, AB_LdEn, ALUOut_LdEn, MDR_LdEn, PC_Sel, PC_LdEn;
  logic          RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Mem_Req, Mem_WrEn;
  logic [3:0]    ALU_func;
  logic [2:0]    State;
  logic [CW-1:0] Instr_Count;

  multicycle_control #(.CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .Mem_Ack(Mem_Ack),
    .IR_LdEn(IR_LdEn), .AB_LdEn(AB_LdEn), .ALUOut_LdEn(ALUOut_LdEn), .MDR_LdEn(MDR_LdEn),
    .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .RF_WrEn(RF_WrEn), .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel), .ALU_func(ALU_func),
    .Mem_Req(Mem_Req), .Mem_WrEn(Mem_WrEn), .State(State), .Instr_Count(Instr_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          ir, ab, aluLd, mdr, pcSel, pcLd, rfWr, rfWd, rfB, aluBin;
    logic [3:0]    func;
    logic          req, wr;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          expQ[$];
  int            tests = 0, fails = 0;
  logic [CW-1:0] cnt = '0;

  localparam logic [5:0] OP_R = 6'b100000, OP_LI = 6'b111000, OP_ADDI = 6'b110000,
    OP_ANDI = 6'b110010, OP_ORI = 6'b110011, OP_BEQ = 6'b000000, OP_BNE = 6'b000001,
    OP_B = 6'b111111, OP_LW = 6'b001111, OP_SW = 6'b011111, OP_NOP = 6'b101010;

  function automatic exp_t model(input int st, input logic [5:0] op, input logic [3:0] fn,
                                 input logic z, input logic ack, input logic [CW-1:0] c);
    exp_t e = '0;
    bit imm = (op == OP_LI) || (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    bit br  = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_B);
    bit mem = (op == OP_LW) || (op == OP_SW);
    e.st  = 3'(st);
    e.cnt = c;
    case (st)
      0: e.ir = 1'b1;
      1: begin e.ab = 1'b1; e.rfB = imm | br | mem; end
      2: begin
        e.aluLd  = 1'b1;
        e.aluBin = imm | mem;
        e.func   = (op == OP_R) ? fn : (op == OP_ANDI) ? 4'd2 : (op == OP_ORI) ? 4'd3 :
                   (op == OP_BEQ || op == OP_BNE) ? 4'd1 : 4'd0;
        if (!(op == OP_R || imm || mem)) begin
          e.pcLd  = 1'b1;
          e.pcSel = (op == OP_B) || (op == OP_BEQ && z) || (op == OP_BNE && !z);
        end
      end
      3: begin
        e.req = 1'b1;
        e.wr  = (op == OP_SW);
        if (ack) begin
          if (op == OP_LW) e.mdr = 1'b1;
          else e.pcLd = 1'b1;
        end
      end
      default: begin e.rfWr = 1'b1; e.pcLd = 1'b1; e.rfWd = (op != OP_LW); end
    endcase
    return e;
  endfunction

  task automatic applyReset(input int n);
    repeat (n) begin
      @(negedge Clk);
      Reset   = 1'b0;
      Instr   = $urandom;
      Mem_Ack = 1'($urandom);
      cnt     = '0;
      expQ.push_back('0);
    end
  endtask

  task automatic doInstr(input logic [5:0] op, input logic [3:0] fn, input logic z,
                         input int w, input int abortAt);
    int    seq[$];
    int    j = 0;
    logic  ack, zz;
    exp_t  e;
    logic [31:0] ins = {op, 22'($urandom), fn};
    seq = '{0, 1, 2};
    if (op == OP_R || op == OP_LI || op == OP_ADDI || op == OP_ANDI || op == OP_ORI)
      seq.push_back(4);
    if (op == OP_LW || op == OP_SW) repeat (w + 1) seq.push_back(3);
    if (op == OP_LW) seq.push_back(4);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abortAt) begin
        applyReset(2);
        return;
      end
      @(negedge Clk);
      Reset = 1'b1;
      Instr = ins;
      zz    = (seq[i] == 2) ? z : 1'($urandom);
      if (seq[i] == 3) begin
        ack = (j == w);
        j++;
      end else ack = 1'($urandom);
      Zero    = zz;
      Mem_Ack = ack;
      e = model(seq[i], op, fn, zz, ack, cnt);
      expQ.push_back(e);
      if (e.pcLd) cnt = cnt + 1'b1;
    end
  endtask

  initial forever begin
    exp_t e, a;
    @(negedge Clk);
    #2;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {State, IR_LdEn, AB_LdEn, ALUOut_LdEn, MDR_LdEn, PC_Sel, PC_LdEn, RF_WrEn,
           RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Mem_Req, Mem_WrEn, Instr_Count};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got %h required %h", $time, a, e);
      end
    end
  end

  initial begin
    logic [5:0] ops[11];
    logic [5:0] op;
    ops = '{OP_R, OP_LI, OP_ADDI, OP_ANDI, OP_ORI, OP_BEQ, OP_BNE, OP_B, OP_LW, OP_SW, OP_NOP};
    applyReset(2);
    doInstr(OP_R,   4'd0, 1'b0, 0, -1);
    doInstr(OP_BEQ, 4'd5, 1'b1, 0, -1);
    doInstr(OP_BEQ, 4'd5, 1'b0, 0, -1);
    doInstr(OP_BNE, 4'd5, 1'b0, 0, -1);
    doInstr(OP_LW,  4'd7, 1'b0, 3, -1);
    doInstr(OP_SW,  4'd7, 1'b0, 0, -1);
    doInstr(OP_SW,  4'd7, 1'b0, 5, 5);   // reset during the memory wait
    doInstr(OP_R,   4'd9, 1'b0, 0, 2);   // reset mid-instruction
    repeat (17) doInstr(OP_NOP, 4'($urandom), 1'($urandom), 0, -1);
    for (int k = 0; k < 200; k++) begin
      op = ($urandom_range(0, 11) == 11) ? 6'($urandom) : ops[$urandom_range(0, 10)];
      doInstr(op, 4'($urandom), 1'($urandom), $urandom_range(0, 3),
              ($urandom_range(0, 19) == 0) ? $urandom_range(0, 5) : -1);
    end
    @(negedge Clk);
    #4;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending required 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
